// File: rtl/disk_sd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : disk_sd_arbiter
// Description : Round-robin sharing of the hps_io SD sector channel between
//               the two Einstein floppy drives, with timeout/short-read abort.
// Revision    : 1.0 - initial release
// ============================================================================
module disk_sd_arbiter #(
    parameter logic [23:0] TIMEOUT_CYC  = 24'd8_000_000,
    parameter logic [9:0]  SECTOR_BYTES = 10'd512
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [1:0]  req_rd,
    input  logic [1:0]  req_wr,
    input  logic [31:0] req_lba0,
    input  logic [31:0] req_lba1,
    input  logic [7:0]  drv_din0,
    input  logic [7:0]  drv_din1,
    output logic [1:0]  grant,
    output logic        busy,
    output logic [1:0]  done,
    output logic [1:0]  err,
    output logic [8:0]  drv_addr,
    output logic [7:0]  drv_dout,
    output logic [1:0]  drv_wr,
    output logic [31:0] sd_lba,
    output logic [1:0]  sd_rd,
    output logic [1:0]  sd_wr,
    input  logic        sd_ack,
    input  logic [8:0]  sd_buff_addr,
    input  logic [7:0]  sd_buff_dout,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_din
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_g;
    logic        r_op_rd;
    logic        r_last;
    logic [23:0] r_tmo;
    logic [9:0]  r_bytes;
    logic [1:0]  r_grant;
    logic [1:0]  r_sd_rd;
    logic [1:0]  r_sd_wr;
    logic [31:0] r_sd_lba;

    logic [1:0]  w_pend;
    logic        w_sel;
    logic [1:0]  w_sel_mask;
    logic [1:0]  w_gmask;
    logic        w_active;
    logic        w_tmo_hit;
    logic        w_short;

    assign w_pend     = req_rd | req_wr;
    // On a tie the drive that was not served last wins.
    assign w_sel      = (w_pend == 2'b11) ? ~r_last : w_pend[1];
    assign w_sel_mask = w_sel ? 2'b10 : 2'b01;
    assign w_gmask    = r_g ? 2'b10 : 2'b01;
    assign w_active   = (r_state == S_REQ) || (r_state == S_XFER);
    assign w_tmo_hit  = w_active && (r_tmo == TIMEOUT_CYC - 24'd1);
    assign w_short    = r_op_rd && (r_bytes < SECTOR_BYTES);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (|w_pend) w_state_nxt = S_REQ;
            S_REQ: begin
                if (w_tmo_hit)   w_state_nxt = S_IDLE;
                else if (sd_ack) w_state_nxt = S_XFER;
            end
            S_XFER: begin
                if (w_tmo_hit)    w_state_nxt = S_IDLE;
                else if (!sd_ack) w_state_nxt = S_FIN;
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_g      <= 1'b0;
            r_op_rd  <= 1'b0;
            r_last   <= 1'b1;
            r_tmo    <= 24'd0;
            r_bytes  <= 10'd0;
            r_grant  <= 2'b00;
            r_sd_rd  <= 2'b00;
            r_sd_wr  <= 2'b00;
            r_sd_lba <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (|w_pend) begin
                        r_g      <= w_sel;
                        r_op_rd  <= req_rd[w_sel];
                        r_sd_lba <= w_sel ? req_lba1 : req_lba0;
                        r_sd_rd  <= req_rd[w_sel] ? w_sel_mask : 2'b00;
                        r_sd_wr  <= req_rd[w_sel] ? 2'b00 : w_sel_mask;
                        r_grant  <= w_sel_mask;
                        r_tmo    <= 24'd0;
                        r_bytes  <= 10'd0;
                    end
                end
                S_REQ, S_XFER: begin
                    r_tmo <= r_tmo + 24'd1;
                    if (w_tmo_hit) begin
                        r_sd_rd <= 2'b00;
                        r_sd_wr <= 2'b00;
                        r_last  <= r_g;
                        r_grant <= 2'b00;
                        r_tmo   <= 24'd0;
                        r_bytes <= 10'd0;
                    end else if (r_state == S_REQ) begin
                        if (sd_ack) begin
                            r_sd_rd <= 2'b00;
                            r_sd_wr <= 2'b00;
                        end
                    end else if (sd_buff_wr && r_op_rd && (r_bytes != SECTOR_BYTES)) begin
                        r_bytes <= r_bytes + 10'd1;
                    end
                end
                S_FIN: begin
                    r_last  <= r_g;
                    r_grant <= 2'b00;
                    r_tmo   <= 24'd0;
                    r_bytes <= 10'd0;
                end
                default: ;
            endcase
        end
    end

    // done/err are decoded from registered state so the requester sees them
    // before the following IDLE cycle samples its request.
    assign grant       = r_grant;
    assign busy        = (r_state != S_IDLE);
    assign done        = ((r_state == S_FIN) && !w_short) ? w_gmask : 2'b00;
    assign err         = (((r_state == S_FIN) && w_short) || w_tmo_hit) ? w_gmask : 2'b00;
    assign drv_addr    = sd_buff_addr;
    assign drv_dout    = sd_buff_dout;
    assign drv_wr      = ((r_state == S_XFER) && sd_buff_wr) ? w_gmask : 2'b00;
    assign sd_lba      = r_sd_lba;
    assign sd_rd       = r_sd_rd;
    assign sd_wr       = r_sd_wr;
    assign sd_buff_din = w_active ? (r_g ? drv_din1 : drv_din0) : 8'd0;

endmodule
`default_nettype wire

// File: tb/tb_disk_sd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_disk_sd_arbiter
// Description : Directed, table-driven bench for disk_sd_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_disk_sd_arbiter;

    logic        clk_sys;
    logic        reset_n;
    logic [1:0]  req_rd;
    logic [1:0]  req_wr;
    logic [31:0] req_lba0;
    logic [31:0] req_lba1;
    logic [7:0]  drv_din0;
    logic [7:0]  drv_din1;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr;

    logic [1:0]  grant, done, err, drv_wr, sd_rd, sd_wr;
    logic        busy;
    logic [8:0]  drv_addr;
    logic [7:0]  drv_dout, sd_buff_din;
    logic [31:0] sd_lba;

    logic [1:0]  t_grant, t_done, t_err, t_drv_wr, t_sd_rd, t_sd_wr;
    logic        t_busy;
    logic [8:0]  t_drv_addr;
    logic [7:0]  t_drv_dout, t_sd_buff_din;
    logic [31:0] t_sd_lba;

    int checks = 0;
    int errors = 0;

    assign drv_din0 = ~sd_buff_addr[7:0];
    assign drv_din1 = sd_buff_addr[7:0];

    disk_sd_arbiter #(.TIMEOUT_CYC(24'd4000), .SECTOR_BYTES(10'd512)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .req_rd(req_rd), .req_wr(req_wr),
        .req_lba0(req_lba0), .req_lba1(req_lba1), .drv_din0(drv_din0), .drv_din1(drv_din1),
        .grant(grant), .busy(busy), .done(done), .err(err), .drv_addr(drv_addr),
        .drv_dout(drv_dout), .drv_wr(drv_wr), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din)
    );

    // Short-timeout instance used only for the stalled-ack scenario.
    disk_sd_arbiter #(.TIMEOUT_CYC(24'd100), .SECTOR_BYTES(10'd512)) dut_t (
        .clk_sys(clk_sys), .reset_n(reset_n), .req_rd(req_rd), .req_wr(req_wr),
        .req_lba0(req_lba0), .req_lba1(req_lba1), .drv_din0(drv_din0), .drv_din1(drv_din1),
        .grant(t_grant), .busy(t_busy), .done(t_done), .err(t_err), .drv_addr(t_drv_addr),
        .drv_dout(t_drv_dout), .drv_wr(t_drv_wr), .sd_lba(t_sd_lba), .sd_rd(t_sd_rd),
        .sd_wr(t_sd_wr), .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr),
        .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr), .sd_buff_din(t_sd_buff_din)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, limit 1000000 time units");
        $fatal(1);
    end

    typedef struct {
        bit          drv;
        bit          rd;
        logic [31:0] lba;
        int          nbytes;
        logic [1:0]  exp_done;
        logic [1:0]  exp_err;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        req_rd = 2'b00; req_wr = 2'b00; sd_ack = 1'b0; sd_buff_wr = 1'b0;
        sd_buff_addr = 9'd0; sd_buff_dout = 8'd0;
        reset_n = 1'b0;
        #20;
        @(negedge clk_sys) reset_n = 1'b1;
        @(posedge clk_sys) #1;
    endtask

    // Entered one cycle into REQ; returns done/err as seen during FIN.
    task automatic serve(input bit drv, input bit rd, input int n,
                         output logic [1:0] dn, output logic [1:0] er);
        logic [1:0] m;
        logic [7:0] exp_din;
        int bad_wr, bad_din, bad_pass, cnt;
        m = drv ? 2'b10 : 2'b01;
        bad_wr = 0; bad_din = 0; bad_pass = 0;
        @(posedge clk_sys) #1;
        sd_ack = 1'b1;
        @(posedge clk_sys) #1;
        chk("ack_clears_req", {sd_rd, sd_wr}, 4'b0000);
        cnt = rd ? n : 512;
        for (int i = 0; i < cnt; i++) begin
            sd_buff_addr = i[8:0];
            sd_buff_dout = i[7:0] ^ 8'h5A;
            sd_buff_wr   = rd;
            @(negedge clk_sys);
            if (drv_wr !== (rd ? m : 2'b00)) bad_wr++;
            if (drv_dout !== (i[7:0] ^ 8'h5A) || drv_addr !== i[8:0]) bad_pass++;
            exp_din = drv ? i[7:0] : ~i[7:0];
            if (sd_buff_din !== exp_din) bad_din++;
            @(posedge clk_sys) #1;
        end
        sd_buff_wr = 1'b0;
        sd_ack     = 1'b0;
        @(posedge clk_sys) #1;
        dn = done;
        er = err;
        chk("drv_wr_route", bad_wr, 0);
        chk("buff_passthru", bad_pass, 0);
        chk("sd_buff_din_route", bad_din, 0);
    endtask

    task automatic do_xfer(input vec_t v);
        logic [1:0] m, dn, er;
        m = v.drv ? 2'b10 : 2'b01;
        if (v.drv) req_lba1 = v.lba; else req_lba0 = v.lba;
        if (v.rd) req_rd = m; else req_wr = m;
        @(posedge clk_sys) #1;
        chk("grant", grant, m);
        chk("req_strobe", {sd_rd, sd_wr}, v.rd ? {m, 2'b00} : {2'b00, m});
        chk("sd_lba", sd_lba, v.lba);
        req_lba0 = 32'hDEAD_BEEF;
        req_lba1 = 32'hCAFE_F00D;
        serve(v.drv, v.rd, v.nbytes, dn, er);
        chk("done", dn, v.exp_done);
        chk("err", er, v.exp_err);
        chk("lba_hold", sd_lba, v.lba);
        @(posedge clk_sys) #1;
        req_rd = 2'b00;
        req_wr = 2'b00;
        chk("released", {grant, busy, done, err}, 7'd0);
        @(posedge clk_sys) #1;
        chk("no_regrant", {grant, sd_rd, sd_wr}, 6'd0);
    endtask

    initial begin
        logic [1:0] dn, er;
        int cyc, nerr, late;

        vecs[0] = '{1'b0, 1'b1, 32'h0000_0012, 512, 2'b01, 2'b00};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_ABCD, 0,   2'b10, 2'b00};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0777, 300, 2'b00, 2'b10};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0055, 0,   2'b01, 2'b00};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_0099, 511, 2'b00, 2'b01};

        req_lba0 = 32'd0; req_lba1 = 32'd0;
        req_rd = 2'b00; req_wr = 2'b00; sd_ack = 1'b0; sd_buff_wr = 1'b0;
        sd_buff_addr = 9'd0; sd_buff_dout = 8'd0;
        reset_n = 1'b0;
        #12;
        chk("reset_ctrl", {grant, busy, done, err, sd_rd, sd_wr, drv_wr}, 13'd0);
        chk("reset_lba", sd_lba, 32'd0);
        chk("reset_din", sd_buff_din, 8'd0);
        chk("reset_t_ctrl", {t_grant, t_busy, t_done, t_err, t_sd_rd, t_sd_wr}, 11'd0);
        @(negedge clk_sys) reset_n = 1'b1;
        @(posedge clk_sys) #1;

        // Simultaneous requests: drive 0 wins from reset, then strict alternation.
        req_lba0 = 32'h100;
        req_lba1 = 32'h200;
        req_rd   = 2'b11;
        for (int rep = 0; rep < 2; rep++) begin
            @(posedge clk_sys) #1;
            chk("rr_grant0", {grant, sd_rd}, 4'b0101);
            chk("rr_lba0", sd_lba, 32'h100);
            serve(1'b0, 1'b1, 512, dn, er);
            chk("rr_done0", {dn, er}, 4'b0100);
            @(posedge clk_sys) #1;
            req_rd[0] = 1'b0;
            chk("rr_gap", grant, 2'b00);
            @(posedge clk_sys) #1;
            chk("rr_grant1", {grant, sd_rd}, 4'b1010);
            chk("rr_lba1", sd_lba, 32'h200);
            serve(1'b1, 1'b1, 512, dn, er);
            chk("rr_done1", {dn, er}, 4'b1000);
            @(posedge clk_sys) #1;
            req_rd = (rep == 0) ? 2'b11 : 2'b00;
            chk("rr_gap2", grant, 2'b00);
        end
        @(posedge clk_sys) #1;
        chk("rr_idle", {grant, busy}, 3'd0);

        for (int k = 0; k < 5; k++) do_xfer(vecs[k]);

        // Stalled ack on the short-timeout instance.
        do_reset();
        req_lba0 = 32'h4444;
        req_rd   = 2'b01;
        @(posedge clk_sys) #1;
        chk("tmo_sd_rd", t_sd_rd, 2'b01);
        cyc = 0;
        nerr = 0;
        while (t_sd_rd[0] && cyc < 300) begin
            @(negedge clk_sys);
            if (t_err == 2'b01) nerr++;
            @(posedge clk_sys) #1;
            cyc++;
        end
        chk("tmo_cycles", cyc, 100);
        chk("tmo_err_pulses", nerr, 1);
        req_rd = 2'b00;
        chk("tmo_idle", {t_grant, t_busy, t_err, t_done}, 7'd0);
        late = 0;
        sd_ack = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c == 3) sd_ack = 1'b0;
            @(negedge clk_sys);
            if ({t_done, t_err, t_grant, t_busy} != 7'd0) late++;
            @(posedge clk_sys) #1;
        end
        chk("late_ack_ignored", late, 0);

        // Asynchronous reset in the middle of a transfer.
        do_reset();
        req_lba0 = 32'h66;
        req_rd   = 2'b01;
        @(posedge clk_sys) #1;
        @(posedge clk_sys) #1;
        sd_ack = 1'b1;
        @(posedge clk_sys) #1;
        sd_buff_wr = 1'b1;
        sd_buff_addr = 9'd5;
        repeat (10) @(posedge clk_sys);
        #2;
        chk("pre_reset_xfer", {busy, drv_wr}, 3'b101);
        reset_n = 1'b0;
        #1;
        chk("async_ctrl", {grant, busy, done, err, sd_rd, sd_wr, drv_wr}, 13'd0);
        chk("async_lba", sd_lba, 32'd0);
        chk("async_din", sd_buff_din, 8'd0);
        sd_ack = 1'b0;
        sd_buff_wr = 1'b0;
        req_lba0 = 32'h77;
        @(negedge clk_sys) reset_n = 1'b1;
        @(posedge clk_sys) #1;
        chk("post_reset_grant", {grant, sd_rd}, 4'b0101);
        chk("post_reset_lba", sd_lba, 32'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
